// File: rtl/fp_sig_normalizer.sv
// Multi-cycle significand normalizer placed after the FP unpacker: shifts f left by up to STEP bits per cycle and subtracts lz from the exponent.
// Optional feature: define NORM_PERF_CNT_EN to add the saturating busy_cnt port that counts SHIFT cycles.
module fp_sig_normalizer #(
    parameter int STEP = 8,
    parameter int EW   = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [52:0]   f_in,
    input  logic [5:0]    lz_in,
    input  logic          fz_in,
    input  logic [EW-1:0] e_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [52:0]   f_out,
    output logic [EW-1:0] e_out,
    output logic          zero_out
`ifdef NORM_PERF_CNT_EN
   ,output logic [15:0]   busy_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // A STEP of 52 or more finishes any legal shift in one cycle, so clamping keeps the compare 6 bits wide.
    localparam logic [5:0] STEP_W = (STEP >= 52) ? 6'd52 : 6'(STEP);
    localparam logic [5:0] LZ_MAX = 6'd52;

    state_e        state_q, state_d;
    logic [52:0]   f_q, f_d;
    logic [EW-1:0] e_q, e_d;
    logic          zero_q, zero_d;
    logic [5:0]    rem_q, rem_d;

    logic [5:0]    lz_clamped;
    logic [5:0]    shift_amt;

    assign lz_clamped = (lz_in > LZ_MAX) ? LZ_MAX : lz_in;
    assign shift_amt  = (rem_q < STEP_W) ? rem_q : STEP_W;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        f_d     = f_q;
        e_d     = e_q;
        zero_d  = zero_q;
        rem_d   = rem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    f_d    = f_in;
                    e_d    = e_in - EW'(lz_clamped);
                    zero_d = 1'b0;
                    rem_d  = lz_clamped;
                    if (fz_in) begin
                        f_d     = '0;
                        e_d     = '0;
                        zero_d  = 1'b1;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else if (lz_clamped == 6'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                f_d   = f_q << shift_amt;
                rem_d = rem_q - shift_amt;
                if (rem_q == shift_amt) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all datapath registers are reset so the outputs read as zero after reset, not just the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            f_q     <= '0;
            e_q     <= '0;
            zero_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state_q <= state_d;
            f_q     <= f_d;
            e_q     <= e_d;
            zero_q  <= zero_d;
            rem_q   <= rem_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign f_out     = f_q;
    assign e_out     = e_q;
    assign zero_out  = zero_q;

`ifdef NORM_PERF_CNT_EN
    logic [15:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if ((state_q == ST_SHIFT) && (busy_cnt_q != 16'hFFFF)) begin
            busy_cnt_d = busy_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_fp_sig_normalizer.sv
// Directed testbench for fp_sig_normalizer (STEP=8, EW=13): reset, shifts, zero operand, backpressure and back-to-back handshakes.
module tb_fp_sig_normalizer;

    localparam int STEP = 8;
    localparam int EW   = 13;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [52:0]   f_in;
    logic [5:0]    lz_in;
    logic          fz_in;
    logic [EW-1:0] e_in;
    logic          out_valid;
    logic          out_ready;
    logic [52:0]   f_out;
    logic [EW-1:0] e_out;
    logic          zero_out;
`ifdef NORM_PERF_CNT_EN
    logic [15:0]   busy_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int hs_count = 0;

    fp_sig_normalizer #(.STEP(STEP), .EW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f_in      (f_in),
        .lz_in     (lz_in),
        .fz_in     (fz_in),
        .e_in      (e_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_out     (f_out),
        .e_out     (e_out),
        .zero_out  (zero_out)
`ifdef NORM_PERF_CNT_EN
       ,.busy_cnt  (busy_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output handshakes, sampled mid-cycle when both signals are settled.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) hs_count++;
    end

    // Presents an operand, waits for acceptance, then counts edges (accept edge = 1) until out_valid.
    task automatic issue(input logic [52:0] f, input logic [5:0] lz, input logic fz,
                         input logic [EW-1:0] e, output int lat);
        int guard = 0;
        f_in = f; lz_in = lz; fz_in = fz; e_in = e;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || f_out !== 53'd0 || e_out !== 13'd0 || zero_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b f_out=%h e_out=%h zero=%b, want 1 0 0 0 0",
                     in_ready, out_valid, f_out, e_out, zero_out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Start a long shift and abort it with an asynchronous reset pulse.
        f_in = 53'h1; lz_in = 6'd52; fz_in = 1'b0; e_in = 13'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_shift_pre: in_ready=%b out_valid=%b, want 0 0", in_ready, out_valid);
        end
        rst_n = 1'b0;
        #2;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || f_out !== 53'd0) begin
            bad++;
            $display("FAIL reset_in_shift: in_ready=%b out_valid=%b f_out=%h, want 1 0 0", in_ready, out_valid, f_out);
        end
        #2;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_aborted_result: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
`ifdef NORM_PERF_CNT_EN
        total++;
        if (busy_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt);
        end
`endif
    endtask

    task automatic test_already_normal();
        int lat;
        issue(53'h1_0000000000001, 6'd0, 1'b0, 13'd5, lat);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL normal_latency: got %0d want 1", lat);
        end
        total++;
        if (f_out !== 53'h1_0000000000001 || e_out !== 13'd5 || zero_out !== 1'b0) begin
            bad++;
            $display("FAIL normal_result: f=%h e=%h z=%b, want 10000000000001 0005 0", f_out, e_out, zero_out);
        end
        pop();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL normal_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_full_shift();
        int lat;
        logic [EW-1:0] exp_e;
        exp_e = -13'sd1074;
        issue(53'h1, 6'd52, 1'b0, -13'sd1022, lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL full_latency: got %0d want 8", lat);
        end
        total++;
        if (f_out !== 53'h1_0000000000000 || e_out !== exp_e || zero_out !== 1'b0) begin
            bad++;
            $display("FAIL full_result: f=%h e=%h z=%b, want 10000000000000 %h 0", f_out, e_out, zero_out, exp_e);
        end
`ifdef NORM_PERF_CNT_EN
        total++;
        if (busy_cnt !== 16'd7) begin
            bad++;
            $display("FAIL full_busy_cnt: got %0d want 7", busy_cnt);
        end
`endif
        pop();
    endtask

    task automatic test_partial_shifts();
        int lat;
        logic [EW-1:0] exp_e;
        // lz equal to STEP: exactly one SHIFT cycle.
        exp_e = -13'sd13;
        issue(53'h1 << 44, 6'd8, 1'b0, -13'sd5, lat);
        total++;
        if (lat !== 2 || f_out !== 53'h1_0000000000000 || e_out !== exp_e) begin
            bad++;
            $display("FAIL step_exact: lat=%0d f=%h e=%h, want 2 10000000000000 %h", lat, f_out, e_out, exp_e);
        end
        pop();
        // lz=10: one full chunk then a 2-bit remainder.
        issue(53'h1 << 42, 6'd10, 1'b0, 13'd100, lat);
        total++;
        if (lat !== 3 || f_out !== 53'h1_0000000000000 || e_out !== 13'd90) begin
            bad++;
            $display("FAIL step_remainder: lat=%0d f=%h e=%h, want 3 10000000000000 005a", lat, f_out, e_out);
        end
        pop();
        // lz above 52 is clamped to 52.
        exp_e = -13'sd52;
        issue(53'h1, 6'd60, 1'b0, 13'd0, lat);
        total++;
        if (lat !== 8 || f_out !== 53'h1_0000000000000 || e_out !== exp_e || zero_out !== 1'b0) begin
            bad++;
            $display("FAIL lz_clamp: lat=%0d f=%h e=%h z=%b, want 8 10000000000000 %h 0", lat, f_out, e_out, zero_out, exp_e);
        end
        pop();
    endtask

    task automatic test_zero();
        int lat;
        issue(53'h1234, 6'd3, 1'b1, 13'd7, lat);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL zero_latency: got %0d want 1", lat);
        end
        total++;
        if (f_out !== 53'd0 || e_out !== 13'd0 || zero_out !== 1'b1) begin
            bad++;
            $display("FAIL zero_result: f=%h e=%h z=%b, want 0 0 1", f_out, e_out, zero_out);
        end
        pop();
        // zero_out must clear for the next non-zero operand.
        issue(53'h1_8000000000000, 6'd0, 1'b0, 13'd1, lat);
        total++;
        if (zero_out !== 1'b0 || f_out !== 53'h1_8000000000000) begin
            bad++;
            $display("FAIL zero_clears: z=%b f=%h, want 0 18000000000000", zero_out, f_out);
        end
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        int hold_bad = 0;
        logic [EW-1:0] exp_e;
        exp_e = -13'sd1;
        issue(53'h0_8000000000000, 6'd1, 1'b0, 13'd0, lat);
        total++;
        if (lat !== 2) begin
            bad++;
            $display("FAIL bp_latency: got %0d want 2", lat);
        end
        // A competing operand presented while busy must be ignored.
        f_in = 53'h3; lz_in = 6'd51; fz_in = 1'b0; e_in = 13'd9; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || f_out !== 53'h1_0000000000000 || e_out !== exp_e)
                hold_bad++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0 (f=%h e=%h)", hold_bad, f_out, e_out);
        end
        pop();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        hs_count  = 0;
        out_ready = 1'b1;
        f_in = 53'h1 << 50; lz_in = 6'd2; fz_in = 1'b0; e_in = 13'd3; in_valid = 1'b1;
        @(posedge clk); #1;                      // A accepted
        f_in = 53'h1_0000000000000; lz_in = 6'd0; e_in = -13'sd7;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy: in_ready=%b want 0", in_ready);
        end
        @(posedge clk); #1;                      // A reaches DONE
        total++;
        if (out_valid !== 1'b1 || f_out !== 53'h1_0000000000000 || e_out !== 13'd1) begin
            bad++;
            $display("FAIL b2b_first: v=%b f=%h e=%h, want 1 10000000000000 0001", out_valid, f_out, e_out);
        end
        @(posedge clk); #1;                      // A handshake, back to IDLE
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;                      // B accepted, straight to DONE
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || f_out !== 53'h1_0000000000000 || e_out !== 13'h1FF9) begin
            bad++;
            $display("FAIL b2b_second: v=%b f=%h e=%h, want 1 10000000000000 1ff9", out_valid, f_out, e_out);
        end
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++;
        if (hs_count !== 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d handshakes want 2", hs_count);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        f_in      = '0;
        lz_in     = '0;
        fz_in     = 1'b0;
        e_in      = '0;
        test_reset();
        test_already_normal();
        test_full_shift();
        test_partial_shifts();
        test_zero();
        test_backpressure();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
